// File: rtl/axi_lite_apb_pkg.sv
// Shared types and response codes for the AXI4-Lite to APB bridge.
package axi_lite_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WR_RESP,
    RD_RESP
  } state_e;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB master bridge.
// Round-robin read/write arbitration; partial-strobe writes fail fast.
module axi_lite_apb_bridge
  import axi_lite_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] aw_addr_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  input  logic [STRB_WIDTH-1:0] w_strb_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  output logic [1:0]            b_resp_o,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  state_e                state_q, state_d;
  logic                  last_wr_q, last_wr_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  b_valid_q, b_valid_d;
  resp_t                 b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  resp_t                 r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic  idle, wr_pend, rd_pend, take_wr, take_rd;
  resp_t apb_resp;

  assign idle    = (state_q == IDLE) && !rst_i;
  assign wr_pend = aw_valid_i && w_valid_i;
  assign rd_pend = ar_valid_i;
  // On a tie the kind not served last wins.
  assign take_wr = idle && wr_pend && (!rd_pend || !last_wr_q);
  assign take_rd = idle && rd_pend && !take_wr;

  assign aw_ready_o = take_wr;
  assign w_ready_o  = take_wr;
  assign ar_ready_o = take_rd;

  assign apb_resp = pslverr_i ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    r_valid_d = r_valid_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    case (state_q)
      IDLE: begin
        if (take_wr) begin
          last_wr_d = 1'b1;
          if (&w_strb_i) begin
            paddr_d  = aw_addr_i;
            pwdata_d = w_data_i;
            pwrite_d = 1'b1;
            psel_d   = 1'b1;
            state_d  = SETUP;
          end else begin
            b_valid_d = 1'b1;
            b_resp_d  = RESP_SLVERR;
            state_d   = WR_RESP;
          end
        end else if (take_rd) begin
          last_wr_d = 1'b0;
          paddr_d   = ar_addr_i;
          pwdata_d  = '0;
          pwrite_d  = 1'b0;
          psel_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pwrite_q) begin
            b_valid_d = 1'b1;
            b_resp_d  = apb_resp;
            state_d   = WR_RESP;
          end else begin
            r_valid_d = 1'b1;
            r_resp_d  = apb_resp;
            r_data_d  = prdata_i;
            state_d   = RD_RESP;
          end
        end
      end
      WR_RESP: begin
        if (b_ready_i) begin
          b_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_RESP: begin
        if (r_ready_i) begin
          r_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
    end
  end

  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign b_valid_o = b_valid_q;
  assign b_resp_o  = b_resp_q;
  assign r_valid_o = r_valid_q;
  assign r_resp_o  = r_resp_q;
  assign r_data_o  = r_data_q;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Randomized bench for axi_lite_apb_bridge with a transaction-level
// scoreboard and a behavioural APB slave.
module tb_axi_lite_apb_bridge;
  import axi_lite_apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aw_addr_i, w_data_i, ar_addr_i;
  logic [3:0]  w_strb_i;
  logic        aw_valid_i, w_valid_i, ar_valid_i;
  logic        aw_ready_o, w_ready_o, ar_ready_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic        b_valid_o, b_ready_i, r_valid_o, r_ready_i;
  logic [31:0] r_data_o, paddr_o, pwdata_o, prdata_i;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;

  always #5 clk = ~clk;

  axi_lite_apb_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i),
    .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o),
    .r_ready_i(r_ready_i),
    .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural APB slave: logs every transfer it sees.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        err;
  } apb_t;

  apb_t        apb_q[$];
  apb_t        cur;
  bit          apb_rand = 0;
  int          fix_wait = 0;
  logic [31:0] fix_rdata = '0;
  logic        fix_err = 0;
  int          wleft = 0;

  initial begin
    pready_i = 0; prdata_i = '0; pslverr_i = 0;
  end

  always @(posedge clk) begin
    #1;
    pready_i  = 0;
    prdata_i  = $urandom;
    pslverr_i = 1'($urandom);
    if (psel_o && !penable_o) begin
      cur.addr  = paddr_o;
      cur.wr    = pwrite_o;
      cur.wdata = pwdata_o;
      cur.waits = apb_rand ? int'($urandom_range(0, 3)) : fix_wait;
      cur.rdata = apb_rand ? $urandom : fix_rdata;
      cur.err   = apb_rand ? ($urandom_range(0, 3) == 0) : fix_err;
      wleft = cur.waits;
      apb_q.push_back(cur);
    end else if (psel_o && penable_o) begin
      chk("apb_hold", {paddr_o, pwrite_o}, {cur.addr, cur.wr});
      if (wleft == 0) begin
        pready_i  = 1;
        prdata_i  = cur.rdata;
        pslverr_i = cur.err;
      end else begin
        wleft--;
      end
    end
  end

  // AXI-side intent and transaction scoreboard.
  bit          aw_v, w_v, ar_v;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0]  w_s;
  bit          busy, resp_seen, last_wr = 1;
  bit          t_wr;
  logic [31:0] t_addr, t_data;
  logic [3:0]  t_strb;
  int          cyc, acc_cyc;
  int          ord_bits;
  int          rdy_prob = 100;
  int          stall, refill_w, refill_r;
  bit          stall_req, auto_gen;
  logic [63:0] snap;

  task automatic new_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    aw_v = 1; w_v = 1; aw_a = a; w_d = d; w_s = s;
  endtask

  task automatic new_rd(input logic [31:0] a);
    ar_v = 1; ar_a = a;
  endtask

  task automatic drive();
    aw_valid_i = aw_v; aw_addr_i = aw_a;
    w_valid_i = w_v; w_data_i = w_d; w_strb_i = w_s;
    ar_valid_i = ar_v; ar_addr_i = ar_a;
  endtask

  function automatic logic [63:0] outs();
    return {27'd0, b_valid_o, b_resp_o, r_valid_o, r_resp_o, r_data_o};
  endfunction

  // Called 1 time unit after a rising edge; returns at the same point
  // of the following cycle.
  task automatic step();
    bit hs_w, hs_r, hs_b, hs_rr, wp, rp, exp_wr;
    int exp_lat;
    resp_t exp_resp;
    apb_t e;
    #1;
    wp = aw_v && w_v;
    rp = ar_v;
    chk("aw_w_ready_pair", aw_ready_o, w_ready_o);
    if (busy) begin
      chk("ready_while_busy", {aw_ready_o, ar_ready_o}, 2'b00);
    end else if (wp || rp) begin
      exp_wr = wp && (!rp || !last_wr);
      chk("grant_wr", aw_ready_o, exp_wr);
      chk("grant_rd", ar_ready_o, !exp_wr);
    end else begin
      chk("ready_no_req", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
    end
    hs_w  = aw_valid_i && aw_ready_o && w_valid_i && w_ready_o;
    hs_r  = ar_valid_i && ar_ready_o;
    hs_b  = b_valid_o && b_ready_i;
    hs_rr = r_valid_o && r_ready_i;
    @(posedge clk);
    cyc++;
    #1;
    if (hs_b || hs_rr) busy = 0;
    if (hs_w || hs_r) begin
      busy = 1; resp_seen = 0; acc_cyc = cyc; last_wr = hs_w;
      t_wr = hs_w; t_addr = hs_w ? aw_a : ar_a; t_data = w_d; t_strb = w_s;
      ord_bits = (ord_bits << 1) | int'(hs_w);
      if (hs_w) begin
        aw_v = 0; w_v = 0;
        if (refill_w > 0) begin
          new_wr($urandom & 32'hFFFC, $urandom, 4'hF); refill_w--;
        end
      end else begin
        ar_v = 0;
        if (refill_r > 0) begin
          new_rd($urandom & 32'hFFFC); refill_r--;
        end
      end
    end
    if (!busy) begin
      chk("valid_idle", {b_valid_o, r_valid_o}, 2'b00);
    end else if (resp_seen) begin
      chk("resp_stable", outs(), snap);
    end else if (b_valid_o || r_valid_o) begin
      resp_seen = 1;
      snap = outs();
      chk("resp_channel", {b_valid_o, r_valid_o}, {t_wr, !t_wr});
      if (t_wr && t_strb != 4'hF) begin
        exp_lat = 1;
        chk("strb_no_apb", apb_q.size(), 0);
        chk("strb_bresp", b_resp_o, RESP_SLVERR);
      end else begin
        chk("apb_count", apb_q.size(), 1);
        exp_lat = 3;
        if (apb_q.size() > 0) begin
          e = apb_q.pop_front();
          exp_lat = 3 + e.waits;
          exp_resp = e.err ? RESP_SLVERR : RESP_OKAY;
          chk("apb_addr", e.addr, t_addr);
          chk("apb_write", e.wr, t_wr);
          chk("apb_wdata", e.wdata, t_wr ? t_data : 32'd0);
          if (t_wr) begin
            chk("bresp", b_resp_o, exp_resp);
          end else begin
            chk("rresp", r_resp_o, exp_resp);
            chk("rdata", r_data_o, e.rdata);
          end
        end
      end
      chk("latency", cyc - acc_cyc + 1, exp_lat);
      if (stall_req) begin
        stall = 3; stall_req = 0;
      end
    end else begin
      chk("valid_early", {b_valid_o, r_valid_o}, 2'b00);
      if (cyc - acc_cyc > 60) begin
        chk("resp_timeout", 0, 1);
        busy = 0;
      end
    end
    if (stall > 0) begin
      b_ready_i = 0; r_ready_i = 0; stall--;
    end else begin
      b_ready_i = ($urandom_range(1, 100) <= rdy_prob);
      r_ready_i = ($urandom_range(1, 100) <= rdy_prob);
    end
    if (auto_gen) begin
      if (!aw_v && !w_v && $urandom_range(0, 2) == 0)
        new_wr($urandom & 32'hFFFC, $urandom,
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      if (!ar_v && $urandom_range(0, 2) == 0)
        new_rd($urandom & 32'hFFFC);
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((busy || aw_v || w_v || ar_v) && n < budget) begin
      step();
      n++;
    end
    chk("idle_budget", (n < budget), 1);
  endtask

  initial begin
    rst = 1;
    aw_v = 0; w_v = 0; ar_v = 0;
    aw_a = '0; w_d = '0; w_s = '0; ar_a = '0;
    b_ready_i = 1; r_ready_i = 1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel_pen", {psel_o, penable_o, pwrite_o}, 3'b000);
    chk("rst_paddr_pwdata", {paddr_o, pwdata_o}, 64'd0);
    chk("rst_valids", {b_valid_o, r_valid_o, b_resp_o, r_resp_o}, 6'd0);
    chk("rst_rdata", r_data_o, 32'd0);
    chk("rst_readies", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b000);
    rst = 0;

    // Single write with two APB wait states.
    fix_wait = 2; fix_err = 0;
    new_wr(32'h1000, 32'hDEADBEEF, 4'hF);
    drive();
    run_until_idle(30);

    // Single read, zero wait states, slave error.
    fix_wait = 0; fix_err = 1; fix_rdata = 32'h12345678;
    new_rd(32'h2004);
    drive();
    run_until_idle(30);

    // Partial strobe write never reaches APB.
    new_wr(32'h3000, 32'hCAFEF00D, 4'h3);
    drive();
    run_until_idle(30);

    // Contention: expect R, W, R, W with one 3-cycle response stall.
    fix_err = 0;
    ord_bits = 0; refill_w = 1; refill_r = 1; stall_req = 1;
    new_wr(32'h4000, 32'h0BADF00D, 4'hF);
    new_rd(32'h4004);
    drive();
    run_until_idle(60);
    chk("contention_order", ord_bits, 4'b0101);

    // Lone AW must not be taken while the read proceeds.
    ord_bits = 0;
    aw_v = 1; aw_a = 32'h5000; w_v = 0; w_d = 32'h55AA55AA; w_s = 4'hF;
    new_rd(32'h5004);
    drive();
    repeat (10) step();
    chk("lone_aw_pending", {aw_v, ar_v}, 2'b10);
    w_v = 1;
    drive();
    run_until_idle(30);
    chk("lone_aw_order", ord_bits, 2'b01);

    // Reset while stuck in ACCESS.
    fix_wait = 30;
    new_rd(32'h6000);
    drive();
    begin
      int n = 0;
      while (!(psel_o && penable_o) && n < 20) begin
        step();
        n++;
      end
      chk("reach_access", psel_o && penable_o, 1);
    end
    step();
    #2;
    rst = 1;
    #1;
    chk("rst_mid_psel", {psel_o, penable_o}, 2'b00);
    chk("rst_mid_valids", {b_valid_o, r_valid_o}, 2'b00);
    busy = 0; last_wr = 1; apb_q.delete();
    aw_v = 0; w_v = 0; ar_v = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    fix_wait = 1; fix_err = 0; fix_rdata = 32'hA5A5_0001;
    new_rd(32'h6008);
    drive();
    run_until_idle(30);

    // Random traffic with random APB timing and response backpressure.
    apb_rand = 1; rdy_prob = 60; auto_gen = 1;
    repeat (2000) step();
    auto_gen = 0;
    run_until_idle(200);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
